// File: rtl/addr_master_arbiter.sv
// rtl/addr_master_arbiter.sv - round-robin arbiter sharing one addr_master write port (optional debug: ADDR_ARB_DBG_EN)
module addr_master_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [3*NUM_REQ-1:0] req_write_to,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 busy,
  output logic [7:0]           am_data_in,
  output logic [2:0]           am_write_to,
  output logic                 am_input_en,
  output logic                 am_output_en
`ifdef ADDR_ARB_DBG_EN
  ,
  output logic [2:0]           dbg_grant,
  output logic [15:0]          dbg_txn_count
`endif
);

  // A zero phase length behaves like one cycle, hence the clamp before the -1.
  localparam logic [7:0] SETUP_LOAD  = (SETUP_CYCLES  > 1) ? 8'(SETUP_CYCLES - 1)  : 8'd0;
  localparam logic [7:0] STROBE_LOAD = (STROBE_CYCLES > 1) ? 8'(STROBE_CYCLES - 1) : 8'd0;
  localparam logic [3:0] NREQ        = 4'(NUM_REQ);
  localparam logic [2:0] LAST_IDX    = 3'(NUM_REQ - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_COMMIT, S_ACK} state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [2:0]         rr_q, rr_d;
  logic [2:0]         grant_q, grant_d;
  logic [7:0]         data_q, data_d;
  logic [2:0]         wt_q, wt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               ien_q, ien_d;
  logic               oen_q, oen_d;

  logic               found;
  logic [2:0]         sel_idx;
  logic [7:0]         sel_data;
  logic [2:0]         sel_wt;
  logic [3:0]         pos;

  // Round-robin search: first asserted requester at or above rr_q, wrapping.
  always_comb begin
    found    = 1'b0;
    sel_idx  = 3'd0;
    sel_data = 8'd0;
    sel_wt   = 3'd0;
    pos      = 4'd0;
    for (int off = 0; off < NUM_REQ; off++) begin
      pos = {1'b0, rr_q} + 4'(off);
      if (pos >= NREQ) pos = pos - NREQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (pos == 4'(i)) && req_valid[i]) begin
          found    = 1'b1;
          sel_idx  = 3'(i);
          sel_data = req_data[8*i +: 8];
          sel_wt   = req_write_to[3*i +: 3];
        end
      end
    end
  end

  // Next-state logic for the capture -> setup -> strobe -> commit -> ack sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    data_d  = data_q;
    wt_d    = wt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LOAD;
          grant_d = sel_idx;
          data_d  = sel_data;
          wt_d    = sel_wt;
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 8'd0) state_d = S_COMMIT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_COMMIT: state_d = S_ACK;
      S_ACK: begin
        state_d = S_IDLE;
        rr_d    = (grant_q == LAST_IDX) ? 3'd0 : grant_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    ien_d  = (state_d == S_STROBE);
    oen_d  = (state_d == S_COMMIT);
    ack_d  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack_d[i] = (state_d == S_ACK) && (grant_q == 3'(i));
    end
  end

  // State, counters, captured request and registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rr_q    <= 3'd0;
      grant_q <= 3'd0;
      data_q  <= 8'd0;
      wt_q    <= 3'd0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      ien_q   <= 1'b0;
      oen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      wt_q    <= wt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      ien_q   <= ien_d;
      oen_q   <= oen_d;
    end
  end

  assign req_ack      = ack_q;
  assign busy         = busy_q;
  assign am_data_in   = data_q;
  assign am_write_to  = wt_q;
  assign am_input_en  = ien_q;
  assign am_output_en = oen_q;

`ifdef ADDR_ARB_DBG_EN
  logic [2:0]  dbg_grant_q;
  logic [15:0] dbg_cnt_q;

  // Last granted index and a wrapping count of completed transactions.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      dbg_grant_q <= 3'd0;
      dbg_cnt_q   <= 16'd0;
    end else begin
      if (state_q == S_IDLE && found) dbg_grant_q <= sel_idx;
      if (state_q == S_ACK)           dbg_cnt_q   <= dbg_cnt_q + 16'd1;
    end
  end

  assign dbg_grant     = dbg_grant_q;
  assign dbg_txn_count = dbg_cnt_q;
`endif

endmodule

// File: tb/tb_addr_master_arbiter.sv
// tb/tb_addr_master_arbiter.sv - directed vector bench for addr_master_arbiter
module tb_addr_master_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  valid;
  logic [11:0] wt;
  logic [31:0] data;
  logic [3:0]  ack;
  logic        busy;
  logic [7:0]  ad;
  logic [2:0]  aw;
  logic        ien;
  logic        oen;
`ifdef ADDR_ARB_DBG_EN
  logic [2:0]  dbg_grant;
  logic [15:0] dbg_txn_count;
`endif

  logic [1:0]  valid2;
  logic [5:0]  wt2;
  logic [15:0] data2;
  logic [1:0]  ack2;
  logic        busy2;
  logic [7:0]  ad2;
  logic [2:0]  aw2;
  logic        ien2;
  logic        oen2;
`ifdef ADDR_ARB_DBG_EN
  logic [2:0]  dbg_grant2;
  logic [15:0] dbg_txn_count2;
`endif

  int n_vec = 0;
  int n_bad = 0;

  addr_master_arbiter dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .req_valid     (valid),
    .req_write_to  (wt),
    .req_data      (data),
    .req_ack       (ack),
    .busy          (busy),
    .am_data_in    (ad),
    .am_write_to   (aw),
    .am_input_en   (ien),
    .am_output_en  (oen)
`ifdef ADDR_ARB_DBG_EN
    ,
    .dbg_grant     (dbg_grant),
    .dbg_txn_count (dbg_txn_count)
`endif
  );

  addr_master_arbiter #(.NUM_REQ(2), .SETUP_CYCLES(3), .STROBE_CYCLES(0)) dut2 (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .req_valid     (valid2),
    .req_write_to  (wt2),
    .req_data      (data2),
    .req_ack       (ack2),
    .busy          (busy2),
    .am_data_in    (ad2),
    .am_write_to   (aw2),
    .am_input_en   (ien2),
    .am_output_en  (oen2)
`ifdef ADDR_ARB_DBG_EN
    ,
    .dbg_grant     (dbg_grant2),
    .dbg_txn_count (dbg_txn_count2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [11:0] wt;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        busy;
    logic [7:0]  ad;
    logic [2:0]  aw;
    logic        ien;
    logic        oen;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [11:0] w, input logic [31:0] d,
                              input logic [3:0] a, input logic b, input logic [7:0] ed,
                              input logic [2:0] ew, input logic ie, input logic oe);
    vec_t r;
    r.valid = v; r.wt = w; r.data = d; r.ack = a; r.busy = b;
    r.ad = ed; r.aw = ew; r.ien = ie; r.oen = oe;
    return r;
  endfunction

  initial begin
    logic [3:0] exp_ack;
    logic [1:0] exp_ack2;
    int p;
    int k;

    // single request from requester 2, then requester 1 dropping/changing its request mid-strobe
    vecs[0]  = mk(4'b0100, 12'h140, 32'h00A5_0000, 4'b0000, 1'b1, 8'hA5, 3'd5, 1'b0, 1'b0);
    vecs[1]  = mk(4'b0100, 12'h140, 32'h00A5_0000, 4'b0000, 1'b1, 8'hA5, 3'd5, 1'b1, 1'b0);
    vecs[2]  = mk(4'b0100, 12'h140, 32'h00A5_0000, 4'b0000, 1'b1, 8'hA5, 3'd5, 1'b1, 1'b0);
    vecs[3]  = mk(4'b0100, 12'h140, 32'h00A5_0000, 4'b0000, 1'b1, 8'hA5, 3'd5, 1'b0, 1'b1);
    vecs[4]  = mk(4'b0100, 12'h140, 32'h00A5_0000, 4'b0100, 1'b1, 8'hA5, 3'd5, 1'b0, 1'b0);
    vecs[5]  = mk(4'b0000, 12'h000, 32'h0000_0000, 4'b0000, 1'b0, 8'hA5, 3'd5, 1'b0, 1'b0);
    vecs[6]  = mk(4'b0000, 12'h000, 32'h0000_0000, 4'b0000, 1'b0, 8'hA5, 3'd5, 1'b0, 1'b0);
    vecs[7]  = mk(4'b0010, 12'h018, 32'h0000_3C00, 4'b0000, 1'b1, 8'h3C, 3'd3, 1'b0, 1'b0);
    vecs[8]  = mk(4'b0010, 12'h018, 32'h0000_3C00, 4'b0000, 1'b1, 8'h3C, 3'd3, 1'b1, 1'b0);
    vecs[9]  = mk(4'b0000, 12'hFFF, 32'hFFFF_FFFF, 4'b0000, 1'b1, 8'h3C, 3'd3, 1'b1, 1'b0);
    vecs[10] = mk(4'b0000, 12'hFFF, 32'hFFFF_FFFF, 4'b0000, 1'b1, 8'h3C, 3'd3, 1'b0, 1'b1);
    vecs[11] = mk(4'b0000, 12'hFFF, 32'hFFFF_FFFF, 4'b0010, 1'b1, 8'h3C, 3'd3, 1'b0, 1'b0);
    vecs[12] = mk(4'b0000, 12'h000, 32'h0000_0000, 4'b0000, 1'b0, 8'h3C, 3'd3, 1'b0, 1'b0);

    rst_n = 1'b0;
    valid = '0; wt = '0; data = '0;
    valid2 = '0; wt2 = '0; data2 = '0;
    repeat (3) @(negedge clk);

    check("rst_ack",  0, 32'(ack),  32'd0);
    check("rst_busy", 0, 32'(busy), 32'd0);
    check("rst_data", 0, 32'(ad),   32'd0);
    check("rst_wt",   0, 32'(aw),   32'd0);
    check("rst_ien",  0, 32'(ien),  32'd0);
    check("rst_oen",  0, 32'(oen),  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      valid = vecs[i].valid;
      wt    = vecs[i].wt;
      data  = vecs[i].data;
      @(posedge clk);
      @(negedge clk);
      check("vec_ack",  i, 32'(ack),  32'(vecs[i].ack));
      check("vec_busy", i, 32'(busy), 32'(vecs[i].busy));
      check("vec_data", i, 32'(ad),   32'(vecs[i].ad));
      check("vec_wt",   i, 32'(aw),   32'(vecs[i].aw));
      check("vec_ien",  i, 32'(ien),  32'(vecs[i].ien));
      check("vec_oen",  i, 32'(oen),  32'(vecs[i].oen));
    end

    // all four requesting continuously: grants 0,1,2,3,0 at 6 cycles each
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    valid = 4'b1111;
    wt    = {3'd4, 3'd5, 3'd6, 3'd7};
    data  = 32'h1312_1110;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk);
      @(negedge clk);
      p = t % 6;
      k = (t / 6) % 4;
      exp_ack = 4'b0000;
      if (p == 4) exp_ack[k] = 1'b1;
      check("rr_ack",  t, 32'(ack),  32'(exp_ack));
      check("rr_busy", t, 32'(busy), (p != 5) ? 32'd1 : 32'd0);
      if (p == 4) begin
        check("rr_data", t, 32'(ad), 32'(8'h10 + 8'(k)));
        check("rr_wt",   t, 32'(aw), 32'(3'd7 - 3'(k)));
      end
    end
    valid = 4'b0000;
`ifdef ADDR_ARB_DBG_EN
    check("dbg_grant", 0, 32'(dbg_grant),     32'd0);
    check("dbg_count", 0, 32'(dbg_txn_count), 32'd5);
`endif

    // reset during strobe: strobe drops at once, no ack, pointer restarts at 0
    valid = 4'b0100;
    wt    = 12'h080;
    data  = 32'h0077_0000;
    @(posedge clk);
    @(negedge clk);
    check("abort_setup_data", 0, 32'(ad), 32'h77);
    @(posedge clk);
    @(negedge clk);
    check("abort_strobe_ien", 0, 32'(ien), 32'd1);
    #1;
    rst_n = 1'b0;
    valid = 4'b1001;
    wt    = {3'd6, 6'd0, 3'd1};
    data  = 32'hD300_00D0;
    #1;
    check("abort_ien",  0, 32'(ien),  32'd0);
    check("abort_busy", 0, 32'(busy), 32'd0);
    check("abort_oen",  0, 32'(oen),  32'd0);
    check("abort_data", 0, 32'(ad),   32'd0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check("abort_ack", j, 32'(ack), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_data", 0, 32'(ad),   32'hD0);
    check("post_rst_wt",   0, 32'(aw),   32'd1);
    check("post_rst_busy", 0, 32'(busy), 32'd1);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_ack", j, 32'(ack), (j == 3) ? 32'd1 : 32'd0);
    end
    valid = 4'b0000;

    // SETUP_CYCLES=3, STROBE_CYCLES=0 instance: one strobe cycle, 7-cycle transaction
    valid2 = 2'b10;
    wt2    = 6'b010_000;
    data2  = 16'h5A00;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      @(negedge clk);
      exp_ack2 = (c == 6) ? 2'b10 : 2'b00;
      check("p2_ien",  c, 32'(ien2),  (c == 4) ? 32'd1 : 32'd0);
      check("p2_oen",  c, 32'(oen2),  (c == 5) ? 32'd1 : 32'd0);
      check("p2_ack",  c, 32'(ack2),  32'(exp_ack2));
      check("p2_busy", c, 32'(busy2), (c <= 6) ? 32'd1 : 32'd0);
      if (c == 1) begin
        check("p2_data", c, 32'(ad2), 32'h5A);
        check("p2_wt",   c, 32'(aw2), 32'd2);
      end
      if (c == 6) valid2 = 2'b00;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
